mul8_shared_ctrl: RTL and testbench



---
 rtl/mul8_shared_ctrl_pkg.sv | 47 ++++
 rtl/mul8_shared_ctrl_mul4x4.sv | 45 ++++
 rtl/mul8_shared_ctrl.sv | 162 ++++++++++++++++
 tb/tb_mul8_shared_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul8_shared_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mul8_shared_ctrl_pkg
// Shared definitions for the sequential 8x8 multiplier controller:
//   - FSM state encoding (IDLE / MUL / DONE)
//   - step count, operand / nibble / product widths
//   - half / full adder helpers used by the 4x4 array multiplier cell
//   - step -> partial-product shift amount helper
// -----------------------------------------------------------------------------
package mul8_shared_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int          MUL_STEPS = 4;
    localparam int          OPND_W    = 8;
    localparam int          NIB_W     = 4;
    localparam int          PROD_W    = 16;
    localparam logic [1:0]  LAST_STEP = 2'(MUL_STEPS - 1);

    // Half adder cell: returns {carry, sum}.
    function automatic logic [1:0] half_add(input logic x, input logic y);
        return {x & y, x ^ y};
    endfunction

    // Full adder cell: returns {carry, sum}.
    function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
        return {(x & y) | (x & ci) | (y & ci), x ^ y ^ ci};
    endfunction

    // Left shift applied to the 8-bit partial product of each step.
    // Steps 1 and 2 are the two cross terms, both weighted by 2^4.
    function automatic logic [3:0] step_shift(input logic [1:0] step);
        logic [3:0] sh;
        case (step)
            2'd0:    sh = 4'd0;
            2'd1:    sh = 4'd4;
            2'd2:    sh = 4'd4;
            2'd3:    sh = 4'd8;
            default: sh = 4'd0;
        endcase
        return sh;
    endfunction

endpackage

// File: rtl/mul8_shared_ctrl_mul4x4.sv
// -----------------------------------------------------------------------------
// mul4x4
// Combinational 4x4 unsigned array multiplier built from half/full adder
// cells. Each row adds the shifted partial-product row (a & b[r]) into the
// running sum with a ripple of adders; the row's carry out becomes the next
// sum bit above the row.
// Ports:
//   a_i [3:0]  multiplicand nibble
//   b_i [3:0]  multiplier nibble
//   p_o [7:0]  product
// -----------------------------------------------------------------------------
module mul4x4
    import mul8_shared_ctrl_pkg::*;
(
    input  logic [NIB_W-1:0]   a_i,
    input  logic [NIB_W-1:0]   b_i,
    output logic [2*NIB_W-1:0] p_o
);

    // Array of adder rows, one per multiplier bit.
    always_comb begin
        logic [7:0] sum_v;
        logic       carry_v;
        logic [1:0] cs_v;
        sum_v   = 8'd0;
        carry_v = 1'b0;
        cs_v    = 2'd0;
        for (int r = 0; r < NIB_W; r++) begin
            carry_v = 1'b0;
            for (int j = 0; j < NIB_W; j++) begin
                if (j == 0) begin
                    cs_v = half_add(sum_v[r+j], a_i[j] & b_i[r]);
                end else begin
                    cs_v = full_add(sum_v[r+j], a_i[j] & b_i[r], carry_v);
                end
                sum_v[r+j] = cs_v[0];
                carry_v    = cs_v[1];
            end
            // Bit r+4 is still zero here: the previous row only reached r+3.
            sum_v[r+NIB_W] = carry_v;
        end
        p_o = sum_v;
    end

endmodule

// File: rtl/mul8_shared_ctrl.sv
// -----------------------------------------------------------------------------
// mul8_shared_ctrl
// Sequential 8x8 unsigned multiplier that time-multiplexes one 4x4 array
// multiplier. Two requesters are arbitrated (round-robin on ties) in IDLE;
// the accepted operands are multiplied nibble-pair by nibble-pair over four
// cycles and the 16-bit product is held in DONE until the consumer takes it.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   req0_valid/ready/a/b    requester 0 handshake and operands
//   req1_valid/ready/a/b    requester 1 handshake and operands
//   rsp_valid/ready         response handshake
//   rsp_p [15:0]            product (registered)
//   rsp_id                  requester that issued the product (registered)
//   busy                    high whenever the FSM is not in IDLE (registered)
// -----------------------------------------------------------------------------
module mul8_shared_ctrl
    import mul8_shared_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [OPND_W-1:0] req0_a,
    input  logic [OPND_W-1:0] req0_b,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [OPND_W-1:0] req1_a,
    input  logic [OPND_W-1:0] req1_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [PROD_W-1:0] rsp_p,
    output logic              rsp_id,
    output logic              busy
);

    state_e              state_q, state_d;
    logic [1:0]          step_q, step_d;
    logic [OPND_W-1:0]   a_q, a_d;
    logic [OPND_W-1:0]   b_q, b_d;
    logic                id_q, id_d;
    logic                last_id_q, last_id_d;
    logic [PROD_W-1:0]   acc_q, acc_d;
    logic                rsp_valid_q;
    logic                busy_q;

    logic                grant_vld_s;
    logic                grant_id_s;
    logic [NIB_W-1:0]    nib_a_s;
    logic [NIB_W-1:0]    nib_b_s;
    logic [2*NIB_W-1:0]  pp_s;
    logic [PROD_W-1:0]   pp_shifted_s;

    // Arbiter: a lone valid wins; on a tie the requester not served last wins.
    always_comb begin
        grant_vld_s = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            grant_id_s = ~last_id_q;
        end else begin
            grant_id_s = req1_valid;
        end
    end

    // Ready is gated by rst_n so nothing looks accepted while reset is held.
    assign req0_ready = rst_n && (state_q == ST_IDLE) && grant_vld_s && !grant_id_s;
    assign req1_ready = rst_n && (state_q == ST_IDLE) && grant_vld_s &&  grant_id_s;

    // Nibble pair for the current step feeding the shared 4x4 cell.
    always_comb begin
        case (step_q)
            2'd0:    begin nib_a_s = a_q[3:0]; nib_b_s = b_q[3:0]; end
            2'd1:    begin nib_a_s = a_q[7:4]; nib_b_s = b_q[3:0]; end
            2'd2:    begin nib_a_s = a_q[3:0]; nib_b_s = b_q[7:4]; end
            2'd3:    begin nib_a_s = a_q[7:4]; nib_b_s = b_q[7:4]; end
            default: begin nib_a_s = a_q[3:0]; nib_b_s = b_q[3:0]; end
        endcase
    end

    mul4x4 u_mul4x4 (
        .a_i (nib_a_s),
        .b_i (nib_b_s),
        .p_o (pp_s)
    );

    assign pp_shifted_s = {8'd0, pp_s} << step_shift(step_q);

    // FSM next state, operand capture and accumulation.
    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        a_d       = a_q;
        b_d       = b_q;
        id_d      = id_q;
        last_id_d = last_id_q;
        acc_d     = acc_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_vld_s) begin
                    a_d       = grant_id_s ? req1_a : req0_a;
                    b_d       = grant_id_s ? req1_b : req0_b;
                    id_d      = grant_id_s;
                    last_id_d = grant_id_s;
                    acc_d     = 16'd0;
                    step_d    = 2'd0;
                    state_d   = ST_MUL;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MUL: begin
                // 255*255 fits in 16 bits, so the sum never carries out.
                acc_d  = acc_q + pp_shifted_s;
                step_d = step_q + 2'd1;
                if (step_q == LAST_STEP) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_MUL;
                end
            end
            ST_DONE: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered output flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            step_q      <= 2'd0;
            a_q         <= 8'd0;
            b_q         <= 8'd0;
            id_q        <= 1'b0;
            last_id_q   <= 1'b1;
            acc_q       <= 16'd0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            a_q         <= a_d;
            b_q         <= b_d;
            id_q        <= id_d;
            last_id_q   <= last_id_d;
            acc_q       <= acc_d;
            rsp_valid_q <= (state_d == ST_DONE);
            busy_q      <= (state_d != ST_IDLE);
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_p     = acc_q;
    assign rsp_id    = id_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mul8_shared_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mul8_shared_ctrl
// Scoreboard bench: every accepted request pushes its expected product/ID,
// every taken response pops and compares. Inputs change 1 time unit after the
// rising edge, outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_mul8_shared_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [7:0]  req0_a, req0_b, req1_a, req1_b;
    logic        rsp_valid, rsp_ready;
    logic [15:0] rsp_p;
    logic        rsp_id;
    logic        busy;

    typedef struct {
        logic        id;
        logic [15:0] p;
        int          acc_cyc;
    } exp_t;

    exp_t sb_q[$];
    int   grant_log[$];
    int   accept_cyc_log[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc_n  = 0;
    logic prev_valid = 1'b0;

    always #5 clk = ~clk;

    mul8_shared_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_p      (rsp_p),
        .rsp_id     (rsp_id),
        .busy       (busy)
    );

    // Falling-edge observer: records acceptances, checks responses.
    task automatic monitor();
        exp_t e;
        logic a0, a1;
        a0 = req0_valid && req0_ready;
        a1 = req1_valid && req1_ready;
        checks++;
        if (a0 && a1) begin
            errors++;
            $display("FAIL grant_exclusive: req0_ready=%0b req1_ready=%0b both accepted", req0_ready, req1_ready);
        end
        if (a0 || a1) begin
            e.id = a1;
            e.p  = a1 ? 16'(req1_a) * 16'(req1_b) : 16'(req0_a) * 16'(req0_b);
            // The acceptance edge is the rising edge after this sample.
            e.acc_cyc = cyc_n + 1;
            sb_q.push_back(e);
            grant_log.push_back(a1 ? 1 : 0);
            accept_cyc_log.push_back(cyc_n + 1);
        end
        if (rsp_valid && !prev_valid && sb_q.size() > 0) begin
            checks++;
            if ((cyc_n - sb_q[0].acc_cyc) !== 4) begin
                errors++;
                $display("FAIL latency: got %0d cycles, expected 4", cyc_n - sb_q[0].acc_cyc);
            end
        end
        if (rsp_valid && rsp_ready) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rsp: got p=%h id=%0b, expected no response", rsp_p, rsp_id);
            end else begin
                e = sb_q.pop_front();
                checks++;
                if (rsp_p !== e.p) begin
                    errors++;
                    $display("FAIL rsp_p: got %h, expected %h", rsp_p, e.p);
                end
                checks++;
                if (rsp_id !== e.id) begin
                    errors++;
                    $display("FAIL rsp_id: got %0b, expected %0b", rsp_id, e.id);
                end
            end
        end
        prev_valid = rsp_valid;
    endtask

    task automatic cyc();
        @(negedge clk);
        cyc_n++;
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_accept();
        int n;
        n = grant_log.size();
        for (int i = 0; i < 30; i++) begin
            cyc();
            if (grant_log.size() > n) break;
        end
        checks++;
        if (grant_log.size() == n) begin
            errors++;
            $display("FAIL accept_timeout: got no acceptance, expected one within 30 cycles");
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 40; i++) begin
            if (sb_q.size() == 0) break;
            cyc();
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d pending responses, expected 0", sb_q.size());
        end
    endtask

    task automatic check_all_zero(input string tag);
        checks++;
        if ({rsp_valid, rsp_p, rsp_id, busy, req0_ready, req1_ready} !== 20'd0) begin
            errors++;
            $display("FAIL %s: got valid=%0b p=%h id=%0b busy=%0b r0=%0b r1=%0b, expected all 0",
                     tag, rsp_valid, rsp_p, rsp_id, busy, req0_ready, req1_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rsp_ready = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = 8'd0; req0_b = 8'd0; req1_a = 8'd0; req1_b = 8'd0;
        #2;
        check_all_zero("reset_values");
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        check_all_zero("reset_ready_gated");
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        cyc();
        check_all_zero("idle_after_reset");
    endtask

    task automatic test_alternate();
        grant_log.delete(); accept_cyc_log.delete();
        req0_a = 8'd12;  req0_b = 8'd13;
        req1_a = 8'd200; req1_b = 8'd3;
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            cyc();
            if (grant_log.size() >= 4) break;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        checks++;
        if (grant_log.size() != 4) begin
            errors++;
            $display("FAIL alt_grant_count: got %0d, expected 4", grant_log.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (grant_log[i] !== (i % 2)) begin
                    errors++;
                    $display("FAIL alt_grant_order[%0d]: got %0d, expected %0d", i, grant_log[i], i % 2);
                end
                if (i > 0) begin
                    checks++;
                    if ((accept_cyc_log[i] - accept_cyc_log[i-1]) !== 6) begin
                        errors++;
                        $display("FAIL alt_spacing[%0d]: got %0d cycles, expected 6", i,
                                 accept_cyc_log[i] - accept_cyc_log[i-1]);
                    end
                end
            end
        end
        drain();
    endtask

    task automatic test_single();
        req0_a = 8'hFF; req0_b = 8'hFF; req0_valid = 1'b1;
        wait_accept();
        req0_valid = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL single_busy: got %0b, expected 1", busy);
        end
        drain();
    endtask

    task automatic test_backpressure();
        logic [15:0] snap_p;
        logic        snap_id;
        int          n;
        rsp_ready = 1'b0;
        req0_a = 8'd3; req0_b = 8'd5; req0_valid = 1'b1;
        wait_accept();
        req0_valid = 1'b0;
        req1_a = 8'd7; req1_b = 8'd9; req1_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (rsp_valid) break;
            cyc();
        end
        snap_p = rsp_p; snap_id = rsp_id;
        checks++;
        if (snap_p !== 16'd15 || snap_id !== 1'b0) begin
            errors++;
            $display("FAIL bp_first_rsp: got p=%h id=%0b, expected p=000f id=0", snap_p, snap_id);
        end
        for (int i = 0; i < 10; i++) begin
            cyc();
            checks++;
            if (rsp_valid !== 1'b1 || rsp_p !== snap_p || rsp_id !== snap_id ||
                req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got valid=%0b p=%h id=%0b r0=%0b r1=%0b, expected 1/%h/%0b/0/0",
                         i, rsp_valid, rsp_p, rsp_id, req0_ready, req1_ready, snap_p, snap_id);
            end
        end
        rsp_ready = 1'b1;
        cyc();
        n = grant_log.size();
        cyc();
        checks++;
        if (grant_log.size() != n + 1 || grant_log[grant_log.size()-1] !== 1) begin
            errors++;
            $display("FAIL bp_release_accept: got %0d new grants, expected req1 accepted in first IDLE cycle",
                     grant_log.size() - n);
        end
        req1_valid = 1'b0;
        drain();
    endtask

    task automatic test_reset_mid();
        int n;
        req0_a = 8'h37; req0_b = 8'h5A; req0_valid = 1'b1;
        wait_accept();
        req0_valid = 1'b0;
        cyc();
        cyc();
        // FSM is now in MUL with step 2 pending.
        req0_a = 8'd2; req0_b = 8'd3; req1_a = 8'd4; req1_b = 8'd5;
        req0_valid = 1'b1; req1_valid = 1'b1;
        rst_n = 1'b0;
        #1;
        check_all_zero("midmul_reset_immediate");
        sb_q.delete();
        cyc();
        cyc();
        check_all_zero("midmul_reset_held");
        rst_n = 1'b1;
        n = grant_log.size();
        cyc();
        checks++;
        if (grant_log.size() != n + 1 || grant_log[grant_log.size()-1] !== 0) begin
            errors++;
            $display("FAIL reset_tie_grant: got %0d new grants (last=%0d), expected one grant to req0",
                     grant_log.size() - n, grant_log[grant_log.size()-1]);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        drain();
        for (int i = 0; i < 8; i++) cyc();
    endtask

    task automatic test_operand_change();
        req0_a = 8'h10; req0_b = 8'h10; req0_valid = 1'b1;
        wait_accept();
        req0_valid = 1'b0;
        req0_a = 8'h20;
        drain();
    endtask

    task automatic test_zero();
        req1_a = 8'h00; req1_b = 8'hAB; req1_valid = 1'b1;
        wait_accept();
        req1_valid = 1'b0;
        drain();
    endtask

    initial begin
        test_reset();
        test_alternate();
        test_single();
        test_backpressure();
        test_reset_mid();
        test_operand_change();
        test_zero();
        for (int i = 0; i < 4; i++) cyc();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
